// File: rtl/cdb_arbiter_pkg.sv
// Shared utils package for the CDB arbiter: word/ROB-tag types, zero constants,
// queue entry layout and grant encoding.
package cdb_arbiter_pkg;
  localparam int unsigned ROB_IDX = 4;
  localparam int unsigned WORD    = 32;

  typedef logic [WORD-1:0]    WORD_TP;
  typedef logic [ROB_IDX-1:0] ROB_IDX_TP;

  localparam ROB_IDX_TP ZERO_ROB_IDX = '0;
  localparam WORD_TP    ZERO_WORD    = '0;
  localparam logic      TRUE         = 1'b1;
  localparam logic      FALSE        = 1'b0;

  typedef struct packed {
    ROB_IDX_TP src;
    WORD_TP    val;
  } cdb_entry_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_e;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-request and CDB broadcast bundle; master = producers/consumer side,
// slave = the arbiter.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic      alu_valid;
  ROB_IDX_TP alu_src;
  WORD_TP    alu_val;
  logic      alu_full;
  logic      ld_valid;
  ROB_IDX_TP ld_src;
  WORD_TP    ld_val;
  logic      ld_full;
  logic      cdb_valid;
  ROB_IDX_TP cdb_src;
  WORD_TP    cdb_val;
  logic      cdb_from_ld;

  modport master (
    output alu_valid, alu_src, alu_val, ld_valid, ld_src, ld_val,
    input  alu_full, ld_full, cdb_valid, cdb_src, cdb_val, cdb_from_ld
  );

  modport slave (
    input  alu_valid, alu_src, alu_val, ld_valid, ld_src, ld_val,
    output alu_full, ld_full, cdb_valid, cdb_src, cdb_val, cdb_from_ld
  );
endinterface

// File: rtl/cdb_arbiter_queue.sv
// cdb_queue: per-requester result FIFO of depth 2^DEPTH_BIT with push, pop,
// flush (highest priority), head and occupancy count.
module cdb_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  cdb_entry_t           push_data,
  output cdb_entry_t           head,
  output logic [DEPTH_BIT:0]   count
);
  localparam int unsigned DEPTH = 1 << DEPTH_BIT;

  cdb_entry_t           mem_q [DEPTH];
  cdb_entry_t           mem_d [DEPTH];
  logic [DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BIT:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + DEPTH_BIT'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + DEPTH_BIT'(1);
      if (push && !pop)      count_d = count_q + (DEPTH_BIT+1)'(1);
      else if (pop && !push) count_d = count_q - (DEPTH_BIT+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/cdb_arbiter.sv
// Two-requester CDB arbiter (ALU, load) with per-requester queues and bypass.
// CDB_RR_EN: round-robin on conflict; otherwise load has fixed priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned QUEUE_BIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rb,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << QUEUE_BIT;

  logic [QUEUE_BIT:0] alu_count, ld_count;
  cdb_entry_t         alu_head, ld_head, alu_in, ld_in, alu_cand, ld_cand;
  logic               alu_head_v, ld_head_v, alu_in_v, ld_in_v;
  logic               alu_cand_v, ld_cand_v, grant_v, grant_ld, grant_alu;
  logic               alu_push, alu_pop, ld_push, ld_pop, active, flush;

  logic       cdb_valid_q, cdb_valid_d;
  cdb_entry_t cdb_q, cdb_d;
  logic       from_ld_q, from_ld_d;
`ifdef CDB_RR_EN
  grant_e     last_q, last_d;
`endif

  assign active = rdy & ~rb;
  assign flush  = rdy & rb;

  assign bus.alu_full = (alu_count == (QUEUE_BIT+1)'(DEPTH));
  assign bus.ld_full  = (ld_count  == (QUEUE_BIT+1)'(DEPTH));

  assign alu_in     = '{src: bus.alu_src, val: bus.alu_val};
  assign ld_in      = '{src: bus.ld_src,  val: bus.ld_val};
  assign alu_head_v = (alu_count != '0);
  assign ld_head_v  = (ld_count  != '0);
  assign alu_in_v   = bus.alu_valid & ~bus.alu_full;
  assign ld_in_v    = bus.ld_valid  & ~bus.ld_full;
  assign alu_cand_v = alu_head_v | alu_in_v;
  assign ld_cand_v  = ld_head_v  | ld_in_v;
  assign alu_cand   = alu_head_v ? alu_head : alu_in;
  assign ld_cand    = ld_head_v  ? ld_head  : ld_in;

  always_comb begin
    grant_v = alu_cand_v | ld_cand_v;
`ifdef CDB_RR_EN
    grant_ld = ld_cand_v & (~alu_cand_v | (last_q == GRANT_ALU));
`else
    grant_ld = ld_cand_v;
`endif
    grant_alu = alu_cand_v & ~grant_ld;

    // A bypassed winner is consumed directly; every other accepted input is queued.
    alu_pop  = active & grant_alu & alu_head_v;
    ld_pop   = active & grant_ld  & ld_head_v;
    alu_push = active & alu_in_v & ~(grant_alu & ~alu_head_v);
    ld_push  = active & ld_in_v  & ~(grant_ld  & ~ld_head_v);

    cdb_valid_d = active & grant_v;
    cdb_d       = cdb_q;
    from_ld_d   = from_ld_q;
    if (active && grant_v) begin
      cdb_d     = grant_ld ? ld_cand : alu_cand;
      from_ld_d = grant_ld;
    end
`ifdef CDB_RR_EN
    last_d = last_q;
    if (active && grant_v) last_d = grant_ld ? GRANT_LD : GRANT_ALU;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= FALSE;
      cdb_q       <= '{src: ZERO_ROB_IDX, val: ZERO_WORD};
      from_ld_q   <= FALSE;
`ifdef CDB_RR_EN
      last_q      <= GRANT_ALU;
`endif
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
      from_ld_q   <= from_ld_d;
`ifdef CDB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  cdb_queue #(.DEPTH_BIT(QUEUE_BIT)) u_alu_q (
    .clk(clk), .rst(rst), .push(alu_push), .pop(alu_pop), .flush(flush),
    .push_data(alu_in), .head(alu_head), .count(alu_count)
  );

  cdb_queue #(.DEPTH_BIT(QUEUE_BIT)) u_ld_q (
    .clk(clk), .rst(rst), .push(ld_push), .pop(ld_pop), .flush(flush),
    .push_data(ld_in), .head(ld_head), .count(ld_count)
  );

  assign bus.cdb_valid   = cdb_valid_q;
  assign bus.cdb_src     = cdb_q.src;
  assign bus.cdb_val     = cdb_q.val;
  assign bus.cdb_from_ld = from_ld_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected broadcasts,
// a negedge monitor pops and compares; plus direct flag/reset checks.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct packed {
    ROB_IDX_TP src;
    WORD_TP    val;
    logic      ld;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic rb  = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  cdb_arbiter_if bus();

  cdb_arbiter #(.QUEUE_BIT(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic expect_b(input int s, input int v, input logic ld);
    exp_t e;
    e.src = ROB_IDX_TP'(s);
    e.val = WORD_TP'(v);
    e.ld  = ld;
    sb.push_back(e);
  endtask

  task automatic step(input logic av, input int as, input int aval,
                      input logic lv, input int ls, input int lval,
                      input logic r, input logic b);
    bus.alu_valid = av;
    bus.alu_src   = ROB_IDX_TP'(as);
    bus.alu_val   = WORD_TP'(aval);
    bus.ld_valid  = lv;
    bus.ld_src    = ROB_IDX_TP'(ls);
    bus.ld_val    = WORD_TP'(lval);
    rdy = r;
    rb  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   64'(bus.cdb_valid),   64'd0);
    chk({tag, "_src"},     64'(bus.cdb_src),     64'd0);
    chk({tag, "_val"},     64'(bus.cdb_val),     64'd0);
    chk({tag, "_from_ld"}, 64'(bus.cdb_from_ld), 64'd0);
    chk({tag, "_alu_full"}, 64'(bus.alu_full),   64'd0);
    chk({tag, "_ld_full"},  64'(bus.ld_full),    64'd0);
  endtask

  // Monitor: every broadcast must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.cdb_valid) begin
        if (sb.size() == 0) chk("unexpected_bcast", 64'(bus.cdb_valid), 64'd0);
        else begin
          e = sb.pop_front();
          chk("bcast_src",     64'(bus.cdb_src),     64'(e.src));
          chk("bcast_val",     64'(bus.cdb_val),     64'(e.val));
          chk("bcast_from_ld", 64'(bus.cdb_from_ld), 64'(e.ld));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.alu_valid = 1'b0; bus.alu_src = '0; bus.alu_val = '0;
    bus.ld_valid  = 1'b0; bus.ld_src  = '0; bus.ld_val  = '0;
    #3;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single uncontested ALU result, 1-cycle latency
    expect_b(3, 'h11, 1'b0);
    step(1'b1, 3, 'h11, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("lat1_valid", 64'(bus.cdb_valid), 64'd1);
    chk("lat1_src",   64'(bus.cdb_src),   64'd3);
    idle();
    chk("lat1_drop", 64'(bus.cdb_valid), 64'd0);
    chk("lat1_hold_src", 64'(bus.cdb_src), 64'd3);

    // Back-to-back conflicts
`ifdef CDB_RR_EN
    expect_b(5, 'hB, 1'b1); expect_b(2, 'hA, 1'b0);
    expect_b(6, 'hD, 1'b1); expect_b(4, 'hC, 1'b0);
`else
    expect_b(5, 'hB, 1'b1); expect_b(6, 'hD, 1'b1);
    expect_b(2, 'hA, 1'b0); expect_b(4, 'hC, 1'b0);
`endif
    step(1'b1, 2, 'hA, 1'b1, 5, 'hB, 1'b1, 1'b0);
    chk("conf1_from_ld", 64'(bus.cdb_from_ld), 64'd1);
    step(1'b1, 4, 'hC, 1'b1, 6, 'hD, 1'b1, 1'b0);
    repeat (4) idle();
    chk("conf_drained", 64'(sb.size()), 64'd0);

`ifndef CDB_RR_EN
    // Load streaming starves ALU until idle
    expect_b(8, 'h80, 1'b1); expect_b(9, 'h90, 1'b1);
    expect_b(10, 'hA0, 1'b1); expect_b(11, 'hB0, 1'b1);
    expect_b(1, 'h10, 1'b0); expect_b(2, 'h20, 1'b0);
    step(1'b1, 1, 'h10, 1'b1, 8, 'h80, 1'b1, 1'b0);
    chk("starve_alu_full0", 64'(bus.alu_full), 64'd0);
    step(1'b1, 2, 'h20, 1'b1, 9, 'h90, 1'b1, 1'b0);
    chk("starve_alu_full1", 64'(bus.alu_full), 64'd1);
    step(1'b0, 0, 0, 1'b1, 10, 'hA0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 11, 'hB0, 1'b1, 1'b0);
    chk("starve_alu_full2", 64'(bus.alu_full), 64'd1);
    chk("starve_ld_full",   64'(bus.ld_full),  64'd0);
    repeat (3) idle();
    chk("starve_alu_free", 64'(bus.alu_full), 64'd0);
`endif

    // Rollback flush with queued results
`ifdef CDB_RR_EN
    expect_b(30, 'h300, 1'b1); expect_b(20, 'h200, 1'b0);
`else
    expect_b(30, 'h300, 1'b1); expect_b(31, 'h310, 1'b1);
`endif
    step(1'b1, 20, 'h200, 1'b1, 30, 'h300, 1'b1, 1'b0);
    step(1'b1, 21, 'h210, 1'b1, 31, 'h310, 1'b1, 1'b0);
`ifndef CDB_RR_EN
    chk("rb_pre_alu_full", 64'(bus.alu_full), 64'd1);
`endif
    step(1'b1, 22, 'h220, 1'b1, 32, 'h320, 1'b1, 1'b1);
    chk("rb_valid",    64'(bus.cdb_valid), 64'd0);
    chk("rb_alu_full", 64'(bus.alu_full),  64'd0);
    chk("rb_ld_full",  64'(bus.ld_full),   64'd0);
    idle();
    chk("rb_after1", 64'(bus.cdb_valid), 64'd0);
    idle();
    chk("rb_after2", 64'(bus.cdb_valid), 64'd0);

    // Stall with queued results, order preserved on resume
`ifdef CDB_RR_EN
    expect_b(50, 'h500, 1'b1); expect_b(40, 'h400, 1'b0);
    expect_b(51, 'h510, 1'b1); expect_b(41, 'h410, 1'b0);
`else
    expect_b(50, 'h500, 1'b1); expect_b(51, 'h510, 1'b1);
    expect_b(40, 'h400, 1'b0); expect_b(41, 'h410, 1'b0);
`endif
    step(1'b1, 40, 'h400, 1'b1, 50, 'h500, 1'b1, 1'b0);
    step(1'b1, 41, 'h410, 1'b1, 51, 'h510, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 0, 1'b1, 52, 'h520, 1'b0, 1'b0);
      chk("stall_valid", 64'(bus.cdb_valid), 64'd0);
    end
    repeat (4) idle();
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-cycle with queued results
    expect_b(70, 'h700, 1'b1);
    step(1'b1, 60, 'h600, 1'b1, 70, 'h700, 1'b1, 1'b0);
    step(1'b1, 61, 'h610, 1'b1, 71, 'h710, 1'b1, 1'b0);
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    chk("arst_pre_valid", 64'(bus.cdb_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    chk("arst_discard1", 64'(bus.cdb_valid), 64'd0);
    idle();
    chk("arst_discard2", 64'(bus.cdb_valid), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter QUEUE_BIT, default 1: log2 of per-requester result queue depth (depth 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rdy, input, 1, global ready; low = stall.
REQ-005 SHALL have port rb, input, 1, rollback/flush request.
REQ-006 SHALL have ports alu_valid, alu_src, alu_val: input, 1 / ROB_IDX / 32; the ALU result request with its ROB tag and value.
REQ-007 SHALL have port alu_full, output, 1, ALU queue cannot accept a result next cycle.
REQ-008 SHALL have ports ld_valid, ld_src, ld_val: input, 1 / ROB_IDX / 32; the load-unit result request.
REQ-009 SHALL have port ld_full, output, 1, load queue cannot accept a result next cycle.
REQ-010 SHALL have ports cdb_valid, cdb_src, cdb_val: output, 1 / ROB_IDX / 32; the registered shared CDB broadcast.
REQ-011 SHALL have port cdb_from_ld, output, 1: 1 = current broadcast came from load unit, 0 = ALU.

Function
REQ-012 SHALL hold one FIFO per requester, depth 2^QUEUE_BIT, entries {src, val}; count register per queue, pointers wrap modulo depth.
REQ-013 SHALL drive xx_full = (count == depth), from registered count only.
REQ-014 SHALL ignore a request whose queue is full; upstream SHALL NOT assert valid while full.
REQ-015 SHALL form each requester's candidate as queue head if non-empty, else the same-cycle incoming request (bypass); an incoming request behind a non-empty queue SHALL be enqueued.
REQ-016 SHALL grant exactly one candidate per active cycle; a granted candidate is popped (or not enqueued if bypassed); the loser stays queued, in order.
REQ-017 SHALL register the grant onto cdb_valid/src/val/from_ld: uncontested latency from xx_valid to cdb_valid is exactly 1 cycle.
REQ-018 SHALL deassert cdb_valid in any cycle with no candidate; src/val then hold their last values.
REQ-019 SHALL permit simultaneous push and pop on one queue; count unchanged.
REQ-020 With rdy low: no push, no pop, inputs discarded, cdb_valid 0 next edge, queues and pointers held.
REQ-021 With rb high and rdy high: both queues emptied, same-cycle inputs discarded, cdb_valid 0 next edge, arbitration pointer kept; rb takes precedence over every other event.

Reset
REQ-022 On rst: cdb_valid 0, cdb_src ZERO_ROB_IDX, cdb_val 0, cdb_from_ld 0, all counts/pointers 0, alu_full 0, ld_full 0, last-grant pointer = ALU.
REQ-023 rst asserted mid-operation SHALL discard all queued results immediately, without waiting for a clock edge.

Configuration
REQ-024 Macro CDB_RR_EN defined: on conflict grant the requester not granted last; last-grant pointer updates on every grant.
REQ-025 CDB_RR_EN undefined: fixed priority, load always wins conflicts; pointer logic absent.

Structure
REQ-026 WORD_TP, ROB_IDX_TP, ZERO_ROB_IDX, ZERO_WORD, TRUE/FALSE SHALL come from the shared utils package; no local redefinition.
REQ-027 SHALL instantiate sub-module cdb_queue (parameterised FIFO exposing push, pop, flush, head, count) twice, once per requester.

Verification
REQ-028 Reset, then alu_valid with src 3, val 0x11 -> next cycle cdb_valid 1, src 3, val 0x11, from_ld 0.
REQ-029 Same cycle: alu (src 2, 0xA), ld (src 5, 0xB), with CDB_RR_EN -> cycle+1 ld 5/0xB, cycle+2 alu 2/0xA; a repeated conflict then grants ALU first.
REQ-030 Without CDB_RR_EN: ld valid every cycle, alu once -> ALU held, alu_full rises after depth pushes, ALU broadcast only when ld idles.
REQ-031 Two results queued in each queue, rb pulse -> cdb_valid 0 next cycle and thereafter, both full flags 0.
REQ-032 rdy low 3 cycles with queued results -> cdb_valid 0 throughout, same order of results resumes after rdy high.
REQ-033 Async rst mid-cycle with full queues -> outputs at reset values before next clk edge.
